huc6260_palette_ctrl: RTL and testbench
=======================================

Name: huc6260_palette_ctrl

Overview:
- Parametrised palette subsystem for the HuC6260 VCE path: a dual-port colour table with a CPU register front-end (address latch, split low/high data access, auto-increment) and a pipelined video lookup port.
- Adds a power-up/reset clear sequencer that walks the whole table, plus a req/ack handshake so the CPU side stalls cleanly while the clear runs.
- Sits between the CPU bus decoder and the pixel colour output stage.

Parameters:
- ADDR_WIDTH, 9, table index width; depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 9, colour word width; must be 9..16. Low byte is bits [7:0]; high part is bits [DATA_WIDTH-1:8].
- CLEAR_VALUE, 0, word written to every entry by the clear sequencer.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cpu_req  in  1  access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_reg  in  2  0 = ADDR_LO, 1 = ADDR_HI, 2 = DATA_LO, 3 = DATA_HI.
- cpu_din  in  8  write data.
- cpu_dout  out  8  read data; valid when cpu_ack = 1.
- cpu_ack  out  1  one-cycle completion pulse.
- busy  out  1  clear sequencer running.
- vid_en  in  1  lookup request for vid_index this cycle.
- vid_index  in  ADDR_WIDTH  pixel palette index.
- vid_colour  out  DATA_WIDTH  looked-up colour.
- vid_valid  out  1  vid_colour is valid.

Behaviour:
Reset and outputs
- While reset_n = 0 (sampled at the clock edge):
  - cpu_dout = 0, cpu_ack = 0, vid_colour = 0, vid_valid = 0.
  - Address register = 0, low-byte latch = 0.
  - Sequencer enters CLEAR with its counter at 0; busy = 1 in the cycle after reset is sampled low.
- Table contents are not reset directly; the sequencer overwrites them.

Sequencer states: CLEAR, IDLE, CPU_RD, CPU_ACK
- CLEAR
  - Writes CLEAR_VALUE to entry [counter] on port A each cycle, counter += 1.
  - After entry 2^ADDR_WIDTH-1 is written, moves to IDLE; busy falls in the same cycle IDLE is entered, exactly 2^ADDR_WIDTH cycles after reset release.
  - cpu_req is ignored (no ack) while in CLEAR.
  - Reset asserted mid-clear restarts the clear at 0.
- IDLE, cpu_req = 1:
  - ADDR_LO write: addr[7:0] = cpu_din. Ack next cycle.
  - ADDR_HI write: addr[ADDR_WIDTH-1:8] = cpu_din low bits. Ack next cycle.
  - DATA_LO write: latch cpu_din. No RAM write. Ack next cycle.
  - DATA_HI write: RAM[addr] = {cpu_din[DATA_WIDTH-9:0], latch}, then addr += 1 modulo depth. Ack next cycle.
  - Any read: go to CPU_RD.
- CPU_RD
  - RAM read issued on port A; data returns 1 cycle later; go to CPU_ACK.
- CPU_ACK
  - cpu_dout and cpu_ack = 1, return to IDLE. Read latency is req to ack = 3 cycles (IDLE, CPU_RD, CPU_ACK).
  - cpu_dout by register:
    - ADDR_LO: addr[7:0].
    - ADDR_HI: addr high bits, zero-extended.
    - DATA_LO: word[7:0].
    - DATA_HI: word high bits, upper unused bits = 1. DATA_HI reads post-increment addr modulo depth.
- Requester must drop cpu_req in the cycle after cpu_ack; a still-high req in IDLE is a new access.
- Address wrap: 2^ADDR_WIDTH-1 increments to 0.

Video port
- Uses port B, read-only.
- vid_colour = RAM[vid_index sampled 2 cycles earlier]; vid_valid = vid_en delayed by 2 cycles.
- When vid_valid = 0, vid_colour holds its last value.
- Same-cycle CPU write and video read of the same entry returns the old word; the new word is visible from the next lookup onward.
- During CLEAR, lookups return whatever was stored at that moment; no stall.

Test Plan:
- Reset held 3 cycles, then released with ADDR_WIDTH = 9 -> busy = 1 for exactly 512 cycles; vid lookups of indices 0, 255 and 511 afterwards return 0 with vid_valid 2 cycles after vid_en.
- cpu_req during CLEAR -> no cpu_ack until busy = 0; first ack 1 cycle after the request is accepted in IDLE.
- Write ADDR_LO = 0x10, ADDR_HI = 0x00, DATA_LO = 0xA5, DATA_HI = 0x01 -> RAM[0x010] = 0x1A5; ADDR_LO then reads 0x11; video lookup of 0x010 gives 0x1A5.
- Set addr to 0x1FF, write a word via DATA_LO/DATA_HI -> addr wraps to 0x000. Read DATA_LO then DATA_HI at 0x010 -> cpu_dout 0xA5 then 0xFF (bit 0 = 1, unused bits = 1); each ack 3 cycles after req.
- CPU DATA_HI write to 0x020 in the same cycle as vid_en with vid_index = 0x020 -> that lookup returns the old value; a lookup 1 cycle later returns the new value.
- reset_n low for 1 cycle mid-clear (counter ≈ 200) -> outputs zero and the clear restarts at 0, taking 512 more cycles.

Source files
------------

// File: rtl/huc6260_palette_ctrl.sv
`default_nettype none
// huc6260_palette_ctrl: dual-port colour table with a CPU register front-end,
// a clear-on-reset sequencer and a two-stage video lookup port.
module huc6260_palette_ctrl #(
  parameter int                    ADDR_WIDTH  = 9,
  parameter int                    DATA_WIDTH  = 9,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [1:0]            cpu_reg,
  input  logic [7:0]            cpu_din,
  output logic [7:0]            cpu_dout,
  output logic                  cpu_ack,
  output logic                  busy,
  input  logic                  vid_en,
  input  logic [ADDR_WIDTH-1:0] vid_index,
  output logic [DATA_WIDTH-1:0] vid_colour,
  output logic                  vid_valid
);

  localparam int         DEPTH       = 1 << ADDR_WIDTH;
  localparam logic [1:0] REG_ADDR_LO = 2'd0;
  localparam logic [1:0] REG_ADDR_HI = 2'd1;
  localparam logic [1:0] REG_DATA_LO = 2'd2;
  localparam logic [1:0] REG_DATA_HI = 2'd3;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    IDLE    = 2'd1,
    CPU_RD  = 2'd2,
    CPU_ACK = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] counter;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            latch;
  logic [1:0]            op_reg;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic                  vid_en_d;

  logic                  accept;
  logic [15:0]           addr_ext;
  logic [15:0]           word_ext;
  logic [7:0]            rd_byte;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // The ack cycle still sees the held request; it must not start a new access.
  assign accept = (state == IDLE) && cpu_req && !cpu_ack;

  always_comb begin
    addr_ext = 16'(addr);
    word_ext = '1;
    word_ext[DATA_WIDTH-1:0] = a_q;
    case (op_reg)
      REG_ADDR_LO: rd_byte = addr_ext[7:0];
      REG_ADDR_HI: rd_byte = addr_ext[15:8];
      REG_DATA_LO: rd_byte = word_ext[7:0];
      default:     rd_byte = word_ext[15:8];
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addr;
    wr_data = DATA_WIDTH'({cpu_din, latch});
    if (reset_n) begin
      if (state == CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = counter;
        wr_data = CLEAR_VALUE;
      end else if (accept && cpu_we && (cpu_reg == REG_DATA_HI)) begin
        wr_en = 1'b1;
      end
    end
  end

  // Read-before-write on both ports: a colliding lookup sees the old word.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    a_q <= mem[addr];
    b_q <= mem[vid_index];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= CLEAR;
      counter  <= '0;
      busy     <= 1'b1;
      addr     <= '0;
      latch    <= '0;
      op_reg   <= REG_ADDR_LO;
      cpu_ack  <= 1'b0;
      cpu_dout <= '0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        CLEAR: begin
          counter <= counter + ADDR_WIDTH'(1);
          if (counter == {ADDR_WIDTH{1'b1}}) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (accept) begin
            op_reg <= cpu_reg;
            if (cpu_we) begin
              cpu_ack <= 1'b1;
              case (cpu_reg)
                REG_ADDR_LO: addr  <= ADDR_WIDTH'({addr_ext[15:8], cpu_din});
                REG_ADDR_HI: addr  <= ADDR_WIDTH'({cpu_din, addr_ext[7:0]});
                REG_DATA_LO: latch <= cpu_din;
                default:     addr  <= addr + ADDR_WIDTH'(1);
              endcase
            end else begin
              state <= CPU_RD;
            end
          end
        end
        CPU_RD: begin
          state <= CPU_ACK;
        end
        CPU_ACK: begin
          cpu_ack  <= 1'b1;
          cpu_dout <= rd_byte;
          state    <= IDLE;
          if (op_reg == REG_DATA_HI) begin
            addr <= addr + ADDR_WIDTH'(1);
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vid_en_d   <= 1'b0;
      vid_valid  <= 1'b0;
      vid_colour <= '0;
    end else begin
      vid_en_d  <= vid_en;
      vid_valid <= vid_en_d;
      if (vid_en_d) begin
        vid_colour <= b_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_huc6260_palette_ctrl.sv
`default_nettype none
// tb_huc6260_palette_ctrl: directed and randomized checks of the palette
// controller against an array-based model of the register/table behaviour.
module tb_huc6260_palette_ctrl;

  localparam int AW    = 9;
  localparam int DW    = 9;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [1:0]    cpu_reg = 2'd0;
  logic [7:0]    cpu_din = 8'd0;
  logic [7:0]    cpu_dout;
  logic          cpu_ack;
  logic          busy;
  logic          vid_en = 1'b0;
  logic [AW-1:0] vid_index = '0;
  logic [DW-1:0] vid_colour;
  logic          vid_valid;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_mem [DEPTH];
  int            m_addr;
  logic [7:0]    m_latch;

  huc6260_palette_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CLEAR_VALUE(9'h000)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_reg   (cpu_reg),
    .cpu_din   (cpu_din),
    .cpu_dout  (cpu_dout),
    .cpu_ack   (cpu_ack),
    .busy      (busy),
    .vid_en    (vid_en),
    .vid_index (vid_index),
    .vid_colour(vid_colour),
    .vid_valid (vid_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int start_addr);
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_addr  = start_addr;
    m_latch = 8'h00;
  endtask

  task automatic model_op(input logic we, input logic [1:0] r, input logic [7:0] d,
                          output logic [7:0] q);
    q = 8'h00;
    if (we) begin
      case (r)
        2'd0: m_addr = (m_addr / 256) * 256 + int'(d);
        2'd1: m_addr = (int'(d) * 256 + m_addr % 256) % DEPTH;
        2'd2: m_latch = d;
        default: begin
          m_mem[m_addr] = DW'((int'(d) * 256 + int'(m_latch)) % (1 << DW));
          m_addr = (m_addr + 1) % DEPTH;
        end
      endcase
    end else begin
      case (r)
        2'd0: q = 8'(m_addr % 256);
        2'd1: q = 8'(m_addr / 256);
        2'd2: q = 8'(int'(m_mem[m_addr]) % 256);
        default: begin
          q = 8'(int'(m_mem[m_addr]) / 256 + 256 - (1 << (DW - 8)));
          m_addr = (m_addr + 1) % DEPTH;
        end
      endcase
    end
  endtask

  // Present a request, wait for the ack, keep req through the ack cycle.
  task automatic cpu_access(input logic we, input logic [1:0] r, input logic [7:0] d,
                            output logic [7:0] q, output int lat);
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = we; cpu_reg = r; cpu_din = d;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!cpu_ack && lat < 50);
    q = cpu_dout;
    @(negedge clock);
    cpu_req = 1'b0;
  endtask

  task automatic do_op(input logic we, input logic [1:0] r, input logic [7:0] d,
                       input string tag, output logic [7:0] q);
    logic [7:0] expd;
    int lat;
    model_op(we, r, d, expd);
    cpu_access(we, r, d, q, lat);
    check({tag, "_lat"}, lat, we ? 1 : 3);
    if (!we) check({tag, "_dout"}, q, expd);
  endtask

  task automatic vid_check(input int idx, input string tag);
    @(negedge clock);
    vid_en = 1'b1; vid_index = AW'(idx);
    @(negedge clock);
    vid_en = 1'b0;
    check({tag, "_early"}, vid_valid, 0);
    @(negedge clock);
    check({tag, "_valid"}, vid_valid, 1);
    check({tag, "_col"}, vid_colour, m_mem[idx]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   cpu_ack, 0);
    check({tag, "_dout"},  cpu_dout, 0);
    check({tag, "_col"},   vid_colour, 0);
    check({tag, "_valid"}, vid_valid, 0);
    check({tag, "_busy"},  busy, 1);
  endtask

  initial begin
    logic [7:0] q;
    logic [DW-1:0] old_word;
    int n;
    logic ack_in_clear;

    // Power-on reset held for three edges, then count busy cycles.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("por");
    reset_n = 1'b1;
    n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge clock);
    end
    check("por_busy_cycles", n, DEPTH);
    model_clear(0);

    vid_check(0, "clr_v0");
    vid_check(255, "clr_v255");
    vid_check(511, "clr_v511");

    // Basic write sequence and post-increment.
    do_op(1'b1, 2'd0, 8'h10, "w_alo", q);
    do_op(1'b1, 2'd1, 8'h00, "w_ahi", q);
    do_op(1'b1, 2'd2, 8'hA5, "w_dlo", q);
    do_op(1'b1, 2'd3, 8'h01, "w_dhi", q);
    do_op(1'b0, 2'd0, 8'h00, "r_alo", q);
    check("r_alo_lit", q, 8'h11);
    vid_check(16, "v_010");
    check("v_010_lit", vid_colour, 9'h1A5);

    // Address wrap from the last entry.
    do_op(1'b1, 2'd0, 8'hFF, "wr_alo", q);
    do_op(1'b1, 2'd1, 8'h01, "wr_ahi", q);
    do_op(1'b1, 2'd2, 8'h3C, "wr_dlo", q);
    do_op(1'b1, 2'd3, 8'h00, "wr_dhi", q);
    do_op(1'b0, 2'd0, 8'h00, "wr_r_alo", q);
    check("wrap_lo_lit", q, 8'h00);
    do_op(1'b0, 2'd1, 8'h00, "wr_r_ahi", q);
    check("wrap_hi_lit", q, 8'h00);
    vid_check(511, "v_1ff");

    do_op(1'b1, 2'd0, 8'h10, "rd_alo", q);
    do_op(1'b0, 2'd2, 8'h00, "rd_dlo", q);
    check("rd_dlo_lit", q, 8'hA5);
    do_op(1'b0, 2'd3, 8'h00, "rd_dhi", q);
    check("rd_dhi_lit", q, 8'hFF);
    do_op(1'b0, 2'd0, 8'h00, "rd_post", q);
    check("rd_post_lit", q, 8'h11);

    // CPU write and video lookup of the same entry in the same cycle.
    do_op(1'b1, 2'd0, 8'h20, "sc_alo", q);
    do_op(1'b1, 2'd2, 8'h5A, "sc_dlo", q);
    old_word = m_mem[32];
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_reg = 2'd3; cpu_din = 8'h01;
    vid_en = 1'b1; vid_index = 9'h020;
    @(negedge clock);
    check("sc_ack", cpu_ack, 1);
    @(negedge clock);
    cpu_req = 1'b0; vid_en = 1'b0;
    check("sc_old_valid", vid_valid, 1);
    check("sc_old_col", vid_colour, old_word);
    @(negedge clock);
    check("sc_new_valid", vid_valid, 1);
    check("sc_new_col", vid_colour, 9'h15A);
    @(negedge clock);
    check("sc_hold_valid", vid_valid, 0);
    check("sc_hold_col", vid_colour, 9'h15A);
    model_op(1'b1, 2'd3, 8'h01, q);

    // One-cycle reset from IDLE, then another one part-way through the clear.
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check_reset_outputs("rst1");
    reset_n = 1'b1;
    repeat (200) @(negedge clock);
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    @(negedge clock);
    check_reset_outputs("rst2");
    reset_n = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_reg = 2'd0; cpu_din = 8'h33;
    n = 0;
    ack_in_clear = 1'b0;
    while (busy && n < 2000) begin
      n++;
      if (cpu_ack) ack_in_clear = 1'b1;
      @(negedge clock);
    end
    check("rst2_busy_cycles", n, DEPTH);
    check("no_ack_in_clear", ack_in_clear, 0);
    check("idle_first_ack", cpu_ack, 0);
    @(negedge clock);
    check("idle_ack", cpu_ack, 1);
    @(negedge clock);
    cpu_req = 1'b0;
    model_clear(8'h33);
    vid_check(16, "reclr_v010");
    do_op(1'b0, 2'd0, 8'h00, "reclr_alo", q);

    // Randomized register traffic and lookups.
    for (int i = 0; i < 120; i++) begin
      int kind;
      logic we;
      logic [1:0] r;
      logic [7:0] d;
      kind = int'($urandom_range(0, 5));
      if (kind == 5) begin
        if ($urandom_range(0, 1) == 1) vid_check((m_addr + DEPTH - 1) % DEPTH, "rnd_vid");
        else vid_check(int'($urandom_range(0, DEPTH - 1)), "rnd_vid");
      end else begin
        we = 1'($urandom_range(0, 1));
        r  = 2'($urandom_range(0, 3));
        d  = 8'($urandom);
        if (we && r == 2'd1) d = 8'($urandom_range(0, 3));
        do_op(we, r, d, "rnd_cpu", q);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
